task_stream_reverse: RTL and testbench
======================================

Name: task_stream_reverse

Overview:
- Parametrised successor to the single-stream task stage in the UART processing path.
- Accepts framed words (i_first / i_last delimited) from the UART RX task chain and re-emits each complete frame in reverse word order.
- Double-buffered (ping-pong) so one frame can be received while the previous one drains.
- Output stream feeds the TX task chain; there is no backpressure on either side.

Parameters:
- TASK_INPUT_WIDTH, 8, input word width.
- TASK_OUTPUT_WIDTH, 8, output word width. Must equal TASK_INPUT_WIDTH; a mismatch is an elaboration error.
- DEPTH, 16, maximum words stored per frame (per bank). Power of 2, at least 2.
- INPUT_STREAMS, 1, kept for task-interface compatibility. Must be 1.
- OUTPUT_STREAMS, 1, kept for task-interface compatibility. Must be 1.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input word valid.
- i_first  in  1  first word of frame; qualified by i_valid.
- i_last  in  1  last word of frame; qualified by i_valid.
- i_data  in  TASK_INPUT_WIDTH  input word.
- o_valid  out  1  output word valid.
- o_last  out  1  final word of the output frame.
- o_data  out  TASK_OUTPUT_WIDTH  output word.
- o_drop  out  1  1-cycle pulse: input frame or word discarded.
- o_trunc  out  1  1-cycle pulse: frame longer than DEPTH was truncated.
- o_busy  out  1  high while either bank holds or is receiving a frame.

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs 0; both banks empty; wr_bank = rd_bank = 0; both FSMs idle.
  - Reset mid-frame or mid-drain aborts immediately: o_valid falls with reset, no partial frame is emitted after release.
- Storage: 2 x DEPTH words, contents not reset. Per bank: full flag and length register (clog2(DEPTH)+1 bits).
- Write FSM, W_IDLE / W_RECV:
  - W_IDLE, i_valid & i_first, bank[wr_bank] empty: write word at address 0, cnt = 1. If i_last is also set, commit immediately (length 1); otherwise go to W_RECV.
  - W_IDLE, i_first with bank[wr_bank] full: discard the whole frame through its i_last. o_drop pulses on the i_first cycle.
  - W_IDLE, i_valid without i_first: word ignored, o_drop pulses.
  - W_RECV, i_valid: write at address cnt while cnt < DEPTH. Words beyond DEPTH are discarded.
  - W_RECV, i_valid & i_last: length = min(N, DEPTH); set bank full; toggle wr_bank; go to W_IDLE. o_trunc pulses this cycle if N > DEPTH.
  - W_RECV, i_valid & i_first: restart the frame in the same bank at address 0; o_drop pulses for the abandoned frame.
- Read FSM, R_IDLE / R_DRAIN:
  - R_IDLE, bank[rd_bank] full: go to R_DRAIN with addr = length-1.
  - R_DRAIN: each cycle register mem[addr] to o_data with o_valid = 1, then decrement addr. o_last = 1 with the address-0 word.
  - On the edge that registers the o_last word: clear the full flag, toggle rd_bank. If the other bank is full, continue R_DRAIN with no idle gap; else go to R_IDLE.
- Latency: i_last sampled at edge k gives the first o_valid after edge k+2, provided the read side is idle.
- Bank freed at edge e is available to an i_first sampled at edge e+1 or later.
- A simultaneous commit by the writer and free by the reader on different banks is legal; both take effect.
- All outputs are registered. o_busy = any full flag | (write FSM in W_RECV).

Optional Feature:
- Macro TASK_STREAM_REVERSE_LEN_TRAILER_EN.
- Defined: after the address-0 word, one extra word carrying the stored length, zero-extended to TASK_OUTPUT_WIDTH, is emitted with o_valid = 1 and o_last = 1. The address-0 word then has o_last = 0, and the bank is freed on the trailer edge.
- Undefined: no trailer; behaviour exactly as above.

Test Plan:
- Frame 01,02,03,04,05, i_last at edge k -> o_data 05,04,03,02,01 on consecutive cycles starting after edge k+2; o_last only with 01.
- Single word AA with i_first & i_last -> one output AA with o_valid = o_last = 1; no o_drop, no o_trunc.
- DEPTH = 16, 20-word frame 00..13h -> o_trunc pulse at the i_last cycle; output 0F..00 (16 words).
- Three back-to-back 8-word frames, frame 3 i_first at the edge after frame 2 i_last -> frame 3 dropped with o_drop pulse; frame 1 and frame 2 emitted reversed, contiguously.
- i_first at word 3 of frame A, then 4-word frame B -> o_drop pulse; only B emitted, reversed. Also: i_valid without i_first in W_IDLE -> o_drop, no output.
- Assert i_rst_n = 0 during the third output word of a drain -> o_valid = 0 immediately; after release o_busy = 0 and no output until a new frame. With TASK_STREAM_REVERSE_LEN_TRAILER_EN defined, frame 01..05 -> 05..01 followed by trailer 05 with o_last.

Source files
------------

// File: rtl/task_stream_reverse.sv
// task_stream_reverse
//
// Frame reverser for the UART task chain. Framed words (i_first / i_last) are
// stored into one of two banks. Each complete frame is then re-emitted in
// reverse word order. While one bank drains, the next frame fills the other
// bank. There is no backpressure on either side.
//
// Optional build macro: TASK_STREAM_REVERSE_LEN_TRAILER_EN.
//   When it is defined, each output frame is followed by one extra word. That
//   word holds the stored length, and it carries o_last instead of the
//   address-0 word.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid          input word valid
//   i_first, i_last  frame delimiters, qualified by i_valid
//   i_data           input word
//   o_valid, o_last  output word valid / final word of the output frame
//   o_data           output word
//   o_drop           1-cycle pulse: an input frame or word was discarded
//   o_trunc          1-cycle pulse: a frame longer than DEPTH was truncated
//   o_busy           a bank holds a frame, or a frame is being received

module task_stream_reverse #(
    parameter int unsigned TASK_INPUT_WIDTH  = 8,
    parameter int unsigned TASK_OUTPUT_WIDTH = 8,
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned INPUT_STREAMS     = 1,
    parameter int unsigned OUTPUT_STREAMS    = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  logic                         i_first,
    input  logic                         i_last,
    input  logic [TASK_INPUT_WIDTH-1:0]  i_data,
    output logic                         o_valid,
    output logic                         o_last,
    output logic [TASK_OUTPUT_WIDTH-1:0] o_data,
    output logic                         o_drop,
    output logic                         o_trunc,
    output logic                         o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DepthL = LW'(DEPTH);

    if (TASK_OUTPUT_WIDTH != TASK_INPUT_WIDTH) begin : gen_width_check
        $error("TASK_OUTPUT_WIDTH must equal TASK_INPUT_WIDTH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (INPUT_STREAMS != 1 || OUTPUT_STREAMS != 1) begin : gen_stream_check
        $error("INPUT_STREAMS and OUTPUT_STREAMS must be 1");
    end

    typedef enum logic [1:0] {StWIdle, StWRecv, StWDrop} wstate_e;
    typedef enum logic [1:0] {StRIdle, StRDrain, StRTrail} rstate_e;

    // Storage: two banks of DEPTH words. The contents are not reset.
    logic [TASK_INPUT_WIDTH-1:0] mem_q [2][DEPTH];

    wstate_e          wstate_q, wstate_d;
    rstate_e          rstate_q, rstate_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    raddr_q, raddr_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic [1:0][LW-1:0] len_q, len_d;

    logic             o_valid_q, o_valid_d;
    logic             o_last_q, o_last_d;
    logic [TASK_OUTPUT_WIDTH-1:0] o_data_q, o_data_d;
    logic             o_drop_q, o_drop_d;
    logic             o_trunc_q, o_trunc_d;
    logic             o_busy_q, o_busy_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic             start;
    logic             commit;
    logic [LW-1:0]    commit_len;
    logic             release_bank;
    logic             free;
    logic             other_bank;
    logic [LW-1:0]    first_len_m1;
    logic [LW-1:0]    next_len_m1;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wstate_q  <= StWIdle;
            rstate_q  <= StRIdle;
            cnt_q     <= '0;
            raddr_q   <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            len_q     <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= '0;
            o_drop_q  <= 1'b0;
            o_trunc_q <= 1'b0;
            o_busy_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            cnt_q     <= cnt_d;
            raddr_q   <= raddr_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            len_q     <= len_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_data_q  <= o_data_d;
            o_drop_q  <= o_drop_d;
            o_trunc_q <= o_trunc_d;
            o_busy_q  <= o_busy_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[wr_bank_q][mem_waddr] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Write side: next state, bank writes, drop/trunc pulses
    // ------------------------------------------------------------------
    always_comb begin
        wstate_d   = wstate_q;
        cnt_d      = cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        start      = 1'b0;
        commit     = 1'b0;
        commit_len = '0;
        o_drop_d   = 1'b0;
        o_trunc_d  = 1'b0;
        if (i_valid) begin
            case (wstate_q)
                StWIdle, StWDrop: begin
                    if (i_first) begin
                        if (!full_q[wr_bank_q]) begin
                            start = 1'b1;
                        end else begin
                            // No free bank: swallow the frame through its i_last.
                            o_drop_d = 1'b1;
                            wstate_d = i_last ? StWIdle : StWDrop;
                        end
                    end else if (wstate_q == StWIdle) begin
                        o_drop_d = 1'b1;
                    end else if (i_last) begin
                        wstate_d = StWIdle;
                    end
                end
                StWRecv: begin
                    if (i_first) begin
                        // Abandon the partial frame and restart in the same bank.
                        start    = 1'b1;
                        o_drop_d = 1'b1;
                    end else begin
                        // cnt saturates at DEPTH; words past that are discarded.
                        if (cnt_q < DepthL) begin
                            mem_we    = 1'b1;
                            mem_waddr = cnt_q[AW-1:0];
                            cnt_d     = cnt_q + LW'(1);
                        end
                        if (i_last) begin
                            commit     = 1'b1;
                            commit_len = cnt_d;
                            o_trunc_d  = (cnt_q == DepthL);
                            wstate_d   = StWIdle;
                        end
                    end
                end
                default: wstate_d = StWIdle;
            endcase
            if (start) begin
                mem_we     = 1'b1;
                mem_waddr  = '0;
                cnt_d      = LW'(1);
                commit     = i_last;
                commit_len = LW'(1);
                wstate_d   = i_last ? StWIdle : StWRecv;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: next state
    // ------------------------------------------------------------------
    assign other_bank   = ~rd_bank_q;
    assign first_len_m1 = len_q[rd_bank_q] - LW'(1);
    assign next_len_m1  = len_q[other_bank] - LW'(1);

    always_comb begin
        rstate_d     = rstate_q;
        raddr_d      = raddr_q;
        rd_bank_d    = rd_bank_q;
        release_bank = 1'b0;
        case (rstate_q)
            StRIdle: begin
                if (full_q[rd_bank_q]) begin
                    rstate_d = StRDrain;
                    raddr_d  = first_len_m1[AW-1:0];
                end
            end
            StRDrain: begin
                raddr_d = raddr_q - AW'(1);
                if (raddr_q == '0) begin
`ifdef TASK_STREAM_REVERSE_LEN_TRAILER_EN
                    rstate_d = StRTrail;
`else
                    release_bank = 1'b1;
`endif
                end
            end
            StRTrail: release_bank = 1'b1;
            default:  rstate_d = StRIdle;
        endcase
        // When the frame ends, chain straight into the other bank if it is already full.
        if (release_bank) begin
            rd_bank_d = other_bank;
            if (full_q[other_bank]) begin
                rstate_d = StRDrain;
                raddr_d  = next_len_m1[AW-1:0];
            end else begin
                rstate_d = StRIdle;
            end
        end
    end

    assign free = release_bank;

    // The writer commits wr_bank, which was empty. The reader frees rd_bank,
    // which was full. So the two updates never land on the same bank.
    always_comb begin
        full_d    = full_q;
        len_d     = len_q;
        wr_bank_d = wr_bank_q;
        if (free) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (commit) begin
            full_d[wr_bank_q] = 1'b1;
            len_d[wr_bank_q]  = commit_len;
            wr_bank_d         = ~wr_bank_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (registered)
    // ------------------------------------------------------------------
    always_comb begin
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
        o_data_d  = '0;
        case (rstate_q)
            StRDrain: begin
                o_valid_d = 1'b1;
                o_data_d  = mem_q[rd_bank_q][raddr_q];
`ifdef TASK_STREAM_REVERSE_LEN_TRAILER_EN
                o_last_d  = 1'b0;
`else
                o_last_d  = (raddr_q == '0);
`endif
            end
            StRTrail: begin
                o_valid_d = 1'b1;
                o_last_d  = 1'b1;
                o_data_d  = TASK_OUTPUT_WIDTH'(len_q[rd_bank_q]);
            end
            default: ;
        endcase
        o_busy_d = (|full_d) | (wstate_d == StWRecv);
    end

    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_data  = o_data_q;
    assign o_drop  = o_drop_q;
    assign o_trunc = o_trunc_q;
    assign o_busy  = o_busy_q;

endmodule

// File: tb/tb_task_stream_reverse.sv
// Directed bench for task_stream_reverse (DEPTH = 16, 8-bit words).
// If TASK_STREAM_REVERSE_LEN_TRAILER_EN is defined, a length-trailer word is expected.

module tb_task_stream_reverse;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid, i_first, i_last;
    logic [7:0] i_data;
    logic       o_valid, o_last, o_drop, o_trunc, o_busy;
    logic [7:0] o_data;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    task_stream_reverse #(
        .TASK_INPUT_WIDTH (8),
        .TASK_OUTPUT_WIDTH(8),
        .DEPTH            (16),
        .INPUT_STREAMS    (1),
        .OUTPUT_STREAMS   (1)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(i_valid),
        .i_first(i_first),
        .i_last (i_last),
        .i_data (i_data),
        .o_valid(o_valid),
        .o_last (o_last),
        .o_data (o_data),
        .o_drop (o_drop),
        .o_trunc(o_trunc),
        .o_busy (o_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic f, input logic l, input logic [7:0] d);
        i_valid = 1'b1;
        i_first = f;
        i_last  = l;
        i_data  = d;
        tick();
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
        i_data  = 8'h00;
    endtask

    // Expect n words hi, hi-1, ... on consecutive cycles (plus trailer if enabled).
    task automatic expect_rev(input string tag, input logic [7:0] hi, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
`ifdef TASK_STREAM_REVERSE_LEN_TRAILER_EN
            chk(tag, {o_valid, o_last, o_data}, {1'b1, 1'b0, hi - 8'(i)});
`else
            chk(tag, {o_valid, o_last, o_data}, {1'b1, (i == n - 1), hi - 8'(i)});
`endif
        end
`ifdef TASK_STREAM_REVERSE_LEN_TRAILER_EN
        tick();
        chk({tag, "_len"}, {o_valid, o_last, o_data}, {1'b1, 1'b1, 8'(n)});
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
        i_data  = 8'h00;
        tick();
        tick();
        chk("reset_outs", {o_valid, o_last, o_data, o_drop, o_trunc, o_busy}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_reset", {o_valid, o_busy}, 32'h0);

        // Frame 01..05 -> 05..01
        send(1'b1, 1'b0, 8'h01);
        chk("f5_busy", {o_busy, o_drop}, 32'h2);
        send(1'b0, 1'b0, 8'h02);
        send(1'b0, 1'b0, 8'h03);
        send(1'b0, 1'b0, 8'h04);
        send(1'b0, 1'b1, 8'h05);
        chk("f5_flags", {o_valid, o_drop, o_trunc}, 32'h0);
        tick();
        chk("f5_lat", {o_valid}, 32'h0);
        expect_rev("f5_out", 8'h05, 5);
        chk("f5_busy_end", {o_busy}, 32'h0);
        tick();
        chk("f5_tail", {o_valid, o_last}, 32'h0);

        // Single-word frame
        send(1'b1, 1'b1, 8'hAA);
        chk("one_flags", {o_drop, o_trunc, o_busy}, 32'h1);
        tick();
        chk("one_lat", {o_valid}, 32'h0);
        expect_rev("one_out", 8'hAA, 1);
        tick();
        chk("one_tail", {o_valid, o_drop, o_trunc}, 32'h0);

        // 20-word frame into DEPTH=16 -> truncated
        for (int i = 0; i < 19; i++) begin
            send(i == 0, 1'b0, 8'(i));
        end
        chk("tr_pre", {o_trunc}, 32'h0);
        send(1'b0, 1'b1, 8'h13);
        chk("tr_pulse", {o_trunc, o_drop}, 32'h2);
        tick();
        chk("tr_pulse_end", {o_trunc, o_valid}, 32'h0);
        expect_rev("tr_out", 8'h0F, 16);
        tick();
        chk("tr_tail", {o_valid, o_busy}, 32'h0);

        // Three back-to-back 8-word frames; third finds both banks full
        fork
            begin
                for (int i = 0; i < 8; i++) send(i == 0, i == 7, 8'h10 + 8'(i));
                for (int i = 0; i < 8; i++) send(i == 0, i == 7, 8'h20 + 8'(i));
                chk("b2b_nodrop", {o_drop}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    send(i == 0, i == 7, 8'h30 + 8'(i));
                    if (i == 0) chk("b2b_drop", {o_drop}, 32'h1);
                end
            end
            begin
                repeat (9) tick();
                expect_rev("b2b_f1", 8'h17, 8);
                expect_rev("b2b_f2", 8'h27, 8);
            end
        join
        tick();
        chk("b2b_tail", {o_valid, o_busy}, 32'h0);

        // Restart mid-frame: only frame B comes out
        send(1'b1, 1'b0, 8'h40);
        send(1'b0, 1'b0, 8'h41);
        send(1'b0, 1'b0, 8'h42);
        send(1'b1, 1'b0, 8'h30);
        chk("rs_drop", {o_drop}, 32'h1);
        send(1'b0, 1'b0, 8'h31);
        chk("rs_drop_end", {o_drop}, 32'h0);
        send(1'b0, 1'b0, 8'h32);
        send(1'b0, 1'b1, 8'h33);
        tick();
        chk("rs_lat", {o_valid}, 32'h0);
        expect_rev("rs_out", 8'h33, 4);
        tick();
        chk("rs_tail", {o_valid}, 32'h0);

        // Stray word with no i_first
        send(1'b0, 1'b0, 8'h55);
        chk("stray_drop", {o_drop, o_busy}, 32'h2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stray_quiet", {o_valid, o_drop, o_busy}, 32'h0);
        end

        // Reset during the third output word
        send(1'b1, 1'b0, 8'h01);
        send(1'b0, 1'b0, 8'h02);
        send(1'b0, 1'b0, 8'h03);
        send(1'b0, 1'b0, 8'h04);
        send(1'b0, 1'b1, 8'h05);
        tick();
        tick();
        chk("rst_w1", {o_valid, o_data}, {1'b1, 8'h05});
        tick();
        chk("rst_w2", {o_valid, o_data}, {1'b1, 8'h04});
        tick();
        chk("rst_w3", {o_valid, o_data}, {1'b1, 8'h03});
        rst_n = 1'b0;
        #1;
        chk("rst_async", {o_valid, o_last, o_data, o_busy}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_quiet", {o_valid, o_busy}, 32'h0);
        end
        send(1'b1, 1'b0, 8'h01);
        send(1'b0, 1'b1, 8'h02);
        tick();
        expect_rev("rst_recover", 8'h02, 2);
        tick();
        chk("rst_recover_tail", {o_valid, o_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
